// File: rtl/bus_stimulus_player.sv
// Replays a stored script of control-word / bus steps against the CPU,
// checking the main bus where asked and counting mismatches.
module bus_stimulus_player #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int CW_W = 32,
   parameter int DEPTH = 64,
   parameter int SETTLE = 1,
   parameter logic [CW_W-1:0] CW_IDLE = 32'h3BF83FCF,
   parameter int ERR_W = 8,
   localparam int IW = $clog2(DEPTH),
   localparam int ENTRY_W = 4 + 2*DATA_W + ADDR_W + CW_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               prog_we,
   input  logic [IW-1:0]      prog_addr,
   input  logic [ENTRY_W-1:0] prog_data,
   input  logic [IW:0]        prog_len,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [CW_W-1:0]    control_word,
   output logic [DATA_W-1:0]  main_bus_o,
   output logic               main_bus_oe,
   input  logic [DATA_W-1:0]  main_bus_i,
   output logic [ADDR_W-1:0]  addr_bus_o,
   output logic               addr_bus_oe,
   output logic               cpu_tick,
   output logic [ERR_W-1:0]   err_count,
   output logic [IW-1:0]      first_err_idx,
   output logic               first_err_valid
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);
   localparam int EXP_LO = CW_W + DATA_W + ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_TICK, S_NEXT, S_DONE
   } state_t;

   state_t state, nstate;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] entry;
   logic [IW-1:0]      idx;
   logic [IW:0]        len;
   logic [IW:0]        idx_inc;
   logic               last;
   logic [SW-1:0]      scnt;
   logic [3:0]         flags;
   logic [DATA_W-1:0]  expect_q;
   logic               ran;

   assign entry = mem[idx];
   assign idx_inc = {1'b0, idx} + (IW+1)'(1);
   assign last = (idx_inc == len);

   // Script RAM is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (prog_we && (state == S_IDLE || state == S_DONE))
         mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         S_IDLE:   if (start)
                      nstate = (prog_len != '0) ? S_APPLY : S_DONE;
         S_APPLY:  nstate = S_SETTLE;
         S_SETTLE: if (scnt == SLAST)
                      nstate = flags[2] ? S_CHECK :
                               flags[3] ? S_TICK : S_NEXT;
         S_CHECK:  nstate = flags[3] ? S_TICK : S_NEXT;
         S_TICK:   nstate = S_NEXT;
         S_NEXT:   nstate = last ? S_DONE : S_APPLY;
         S_DONE:   nstate = S_IDLE;
         default:  nstate = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != S_IDLE) && (state != S_DONE || ran);
      done     = (state == S_DONE);
      cpu_tick = (state == S_TICK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx             <= '0;
         len             <= '0;
         scnt            <= '0;
         flags           <= '0;
         expect_q        <= '0;
         ran             <= 1'b0;
         control_word    <= CW_IDLE;
         main_bus_o      <= '0;
         main_bus_oe     <= 1'b0;
         addr_bus_o      <= '0;
         addr_bus_oe     <= 1'b0;
         err_count       <= '0;
         first_err_idx   <= '0;
         first_err_valid <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (start) begin
               ran <= (prog_len != '0);
               if (prog_len != '0) begin
                  len             <= prog_len;
                  idx             <= '0;
                  err_count       <= '0;
                  first_err_idx   <= '0;
                  first_err_valid <= 1'b0;
               end
            end
            S_APPLY: begin
               flags        <= entry[ENTRY_W-1 -: 4];
               expect_q     <= entry[EXP_LO +: DATA_W];
               addr_bus_o   <= entry[CW_W+DATA_W +: ADDR_W];
               addr_bus_oe  <= entry[ENTRY_W-3];
               main_bus_o   <= entry[CW_W +: DATA_W];
               main_bus_oe  <= entry[ENTRY_W-4];
               control_word <= entry[CW_W-1:0];
               scnt         <= '0;
            end
            S_SETTLE: scnt <= scnt + SW'(1);
            S_CHECK: if (main_bus_i != expect_q) begin
               if (err_count != '1)
                  err_count <= err_count + ERR_W'(1);
               if (!first_err_valid) begin
                  first_err_idx   <= idx;
                  first_err_valid <= 1'b1;
               end
            end
            // Step drive values persist through NEXT; only the last step
            // hands the buses back to idle on its way to DONE.
            S_NEXT: begin
               idx <= idx_inc[IW-1:0];
               if (last) begin
                  control_word <= CW_IDLE;
                  main_bus_o   <= '0;
                  main_bus_oe  <= 1'b0;
                  addr_bus_o   <= '0;
                  addr_bus_oe  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_stimulus_player.sv
// Randomised and directed bench for bus_stimulus_player with a script
// interpreter model and a byte-wide RAM standing in for the CPU side.
module tb_bus_stimulus_player;

   localparam int DW = 8;
   localparam int AW = 16;
   localparam int CWW = 32;
   localparam int DEPTH = 512;
   localparam int SETTLE = 2;
   localparam int ERR_W = 8;
   localparam int IW = 9;
   localparam int EW = 4 + 2*DW + AW + CWW;
   localparam logic [31:0] CW_IDLE = 32'h3BF83FCF;

   logic            clk = 1'b0;
   logic            rst;
   logic            prog_we;
   logic [IW-1:0]   prog_addr;
   logic [EW-1:0]   prog_data;
   logic [IW:0]     prog_len;
   logic            start;
   logic            busy;
   logic            done;
   logic [CWW-1:0]  control_word;
   logic [DW-1:0]   main_bus_o;
   logic            main_bus_oe;
   logic [DW-1:0]   main_bus_i;
   logic [AW-1:0]   addr_bus_o;
   logic            addr_bus_oe;
   logic            cpu_tick;
   logic [ERR_W-1:0] err_count;
   logic [IW-1:0]   first_err_idx;
   logic            first_err_valid;

   int vectors = 0;
   int errors = 0;

   logic [EW-1:0] script [DEPTH];
   logic [7:0]    ram [65536];
   logic [7:0]    model_ram [65536];
   logic [7:0]    m_err;
   logic [IW-1:0] m_first;
   logic          m_valid;

   always #5 clk = ~clk;

   assign main_bus_i = main_bus_oe ? main_bus_o : ram[addr_bus_o];

   bus_stimulus_player #(
      .DATA_W(DW), .ADDR_W(AW), .CW_W(CWW), .DEPTH(DEPTH),
      .SETTLE(SETTLE), .CW_IDLE(CW_IDLE), .ERR_W(ERR_W)
   ) dut (
      .clk(clk), .rst(rst),
      .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len),
      .start(start), .busy(busy), .done(done),
      .control_word(control_word),
      .main_bus_o(main_bus_o), .main_bus_oe(main_bus_oe),
      .main_bus_i(main_bus_i),
      .addr_bus_o(addr_bus_o), .addr_bus_oe(addr_bus_oe),
      .cpu_tick(cpu_tick), .err_count(err_count),
      .first_err_idx(first_err_idx),
      .first_err_valid(first_err_valid)
   );

   function automatic logic [EW-1:0] mk(
      input logic [3:0] f, input logic [7:0] ex,
      input logic [15:0] a, input logic [7:0] d,
      input logic [31:0] cw);
      return {f, ex, a, d, cw};
   endfunction

   task automatic put(input int i, input logic [EW-1:0] e);
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = IW'(i);
      prog_data = e;
      script[i] = e;
   endtask

   task automatic put_end();
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Interprets script[0..len-1] step by step, then runs the DUT.
   task automatic run_check(input string name, input int len);
      logic [EW-1:0] e;
      logic [3:0] f;
      logic [7:0] ex, d, obs;
      logic [15:0] a;
      logic [EW-1:0] q_e[$];
      logic [57:0] got, want;
      int exp_cyc, n, busy_bad;
      bit seen;
      exp_cyc = 2;
      if (len > 0) begin
         m_err = 0;
         m_first = 0;
         m_valid = 0;
      end
      for (int i = 0; i < len; i++) begin
         e = script[i];
         f = e[EW-1 -: 4];
         ex = e[CWW+DW+AW +: DW];
         a = e[CWW+DW +: AW];
         d = e[CWW +: DW];
         exp_cyc += 2 + SETTLE + int'(f[2]) + int'(f[3]);
         if (f[2]) begin
            obs = f[0] ? d : model_ram[a];
            if (obs != ex) begin
               if (m_err != 8'hFF) m_err++;
               if (!m_valid) begin
                  m_first = IW'(i);
                  m_valid = 1'b1;
               end
            end
         end
         if (f[3]) begin
            q_e.push_back(e);
            if (f[0] && f[1]) model_ram[a] = d;
         end
      end
      @(negedge clk);
      prog_len = (IW+1)'(len);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      busy_bad = 0;
      seen = 0;
      for (int k = 0; k < 4000; k++) begin
         n++;
         if (cpu_tick) begin
            vectors++;
            got = {control_word, main_bus_oe, main_bus_o,
                   addr_bus_oe, addr_bus_o};
            if (q_e.size() == 0) begin
               errors++;
               $display("FAIL %s tick: unexpected tick at cycle %0d",
                        name, n);
            end else begin
               e = q_e.pop_front();
               want = {e[CWW-1:0], e[EW-4], e[CWW +: DW],
                       e[EW-3], e[CWW+DW +: AW]};
               if (got !== want) begin
                  errors++;
                  $display("FAIL %s tick_drive: got %h want %h",
                           name, got, want);
               end
            end
            if (main_bus_oe && addr_bus_oe)
               ram[addr_bus_o] = main_bus_o;
         end
         if (busy !== (len > 0)) busy_bad++;
         if (done === 1'b1) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      vectors++;
      if (!seen) begin
         errors++;
         $display("FAIL %s done: not seen within bound", name);
      end
      vectors++;
      if (n != exp_cyc) begin
         errors++;
         $display("FAIL %s cycles: got %0d want %0d", name, n, exp_cyc);
      end
      vectors++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL %s busy: %0d bad cycles want 0", name, busy_bad);
      end
      vectors++;
      if (q_e.size() != 0) begin
         errors++;
         $display("FAIL %s ticks: %0d missing want 0", name, q_e.size());
      end
      vectors++;
      if (err_count !== m_err) begin
         errors++;
         $display("FAIL %s err_count: got %0d want %0d",
                  name, err_count, m_err);
      end
      vectors++;
      if ({first_err_valid, first_err_idx} !== {m_valid, m_first}) begin
         errors++;
         $display("FAIL %s first_err: got %b/%0d want %b/%0d", name,
                  first_err_valid, first_err_idx, m_valid, m_first);
      end
      @(negedge clk);
      vectors++;
      if ({done, busy, main_bus_oe, addr_bus_oe, control_word} !==
          {4'b0000, CW_IDLE}) begin
         errors++;
         $display("FAIL %s post_done: got %b%b%b%b %h want 0000 %h",
                  name, done, busy, main_bus_oe, addr_bus_oe,
                  control_word, CW_IDLE);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      prog_we = 0;
      prog_addr = '0;
      prog_data = '0;
      prog_len = '0;
      start = 0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({control_word, main_bus_oe, addr_bus_oe, busy, done,
           cpu_tick, err_count, first_err_valid} !==
          {CW_IDLE, 5'b00000, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset: cw %h oe %b%b busy %b done %b err %0d",
                  control_word, main_bus_oe, addr_bus_oe, busy,
                  done, err_count);
      end
      vectors++;
      if ({main_bus_o, addr_bus_o, first_err_idx} !== '0) begin
         errors++;
         $display("FAIL reset_vals: got %h %h %0d want 0",
                  main_bus_o, addr_bus_o, first_err_idx);
      end
      rst = 1'b0;
      m_err = 0;
      m_first = 0;
      m_valid = 0;
   endtask

   task automatic test_load_add();
      put(0, mk(4'b1011, 8'h00, 16'h0010, 8'd24, 32'h0000_1001));
      put(1, mk(4'b1011, 8'h00, 16'h0011, 8'd18, 32'h0000_1002));
      put(2, mk(4'b1011, 8'h00, 16'h0012, 8'd42, 32'h0000_2003));
      put(3, mk(4'b0110, 8'd42, 16'h0012, 8'h00, 32'h0000_3004));
      put_end();
      run_check("load_add", 4);
   endtask

   task automatic test_ram();
      put(0, mk(4'b1011, 8'h00, 16'h1234, 8'h54, 32'hA000_0001));
      put(1, mk(4'b0110, 8'h54, 16'h1234, 8'h00, 32'hA000_0002));
      put(2, mk(4'b1000, 8'h00, 16'h0000, 8'h00, 32'hA000_0003));
      put(3, mk(4'b0110, 8'h55, 16'h1234, 8'h00, 32'hA000_0004));
      put_end();
      run_check("ram", 4);
   endtask

   task automatic test_zero_len();
      run_check("zero_len", 0);
   endtask

   task automatic test_saturation();
      logic [7:0] d;
      for (int i = 0; i < 300; i++) begin
         d = 8'($urandom);
         put(i, mk(4'b0101, ~d, 16'($urandom), d, $urandom));
      end
      put_end();
      fork
         run_check("saturate", 300);
         begin
            for (int k = 0; k < 50; k++) begin
               @(negedge clk);
               if (busy) break;
            end
            for (int j = 0; j < 20; j++) begin
               @(negedge clk);
               prog_we = 1'b1;
               prog_addr = IW'(j);
               prog_data = mk(4'b0000, 8'h00, 16'h0, 8'h0, 32'h0);
            end
            @(negedge clk);
            prog_we = 1'b0;
         end
      join
      run_check("we_during_run", 1);
   endtask

   task automatic test_random();
      logic [3:0] f;
      logic [15:0] a;
      logic [7:0] d, ex;
      int len;
      for (int r = 0; r < 6; r++) begin
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) begin
            f = 4'($urandom);
            case ($urandom_range(0, 2))
               0: a = 16'h1234;
               1: a = 16'h0010;
               default: a = 16'($urandom);
            endcase
            d = 8'($urandom);
            ex = ($urandom_range(0, 1) == 1) ?
                 (f[0] ? d : model_ram[a]) : 8'($urandom);
            put(i, mk(f, ex, a, d, $urandom));
         end
         put_end();
         run_check("random", len);
      end
   endtask

   task automatic test_reset_mid_run();
      int tc;
      bit hit;
      for (int i = 0; i < 4; i++)
         put(i, mk(4'b1000, 8'h0, 16'($urandom), 8'($urandom),
                   $urandom));
      put_end();
      @(negedge clk);
      prog_len = (IW+1)'(4);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      tc = 0;
      hit = 0;
      for (int k = 0; k < 200; k++) begin
         if (cpu_tick) tc++;
         if (tc == 3) begin
            rst = 1'b1;
            #1;
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      vectors++;
      if (!hit) begin
         errors++;
         $display("FAIL mid_rst: third tick not seen, got %0d ticks", tc);
      end
      vectors++;
      if ({cpu_tick, busy, done, main_bus_oe, addr_bus_oe,
           control_word, main_bus_o, addr_bus_o, err_count,
           first_err_valid} !==
          {5'b00000, CW_IDLE, 8'h00, 16'h0000, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL mid_rst_outputs: tick %b busy %b cw %h oe %b%b",
                  cpu_tick, busy, control_word, main_bus_oe,
                  addr_bus_oe);
      end
      @(negedge clk);
      rst = 1'b0;
      m_err = 0;
      m_first = 0;
      m_valid = 0;
      run_check("rerun", 4);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
         model_ram[i] = ram[i];
      end
      test_reset();
      test_load_add();
      test_ram();
      test_zero_len();
      test_saturation();
      test_random();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
